// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared datapath control-word layout, encodings and bubble constant
package datapath_pkg;

    localparam int CTRL_W = 20;

    // ALU operation encodings carried in the control word.
    typedef enum logic [3:0] {
        ALU_SLL     = 4'd0,
        ALU_SRL     = 4'd1,
        ALU_SRA     = 4'd2,
        ALU_ADD     = 4'd3,
        ALU_SUB     = 4'd4,
        ALU_AND     = 4'd5,
        ALU_OR      = 4'd6,
        ALU_XOR     = 4'd7,
        ALU_NOR     = 4'd8,
        ALU_SLT     = 4'd9,
        ALU_INVALID = 4'hF
    } alu_op_e;

    // Load width encodings.
    typedef enum logic [1:0] {
        MRW_WORD = 2'd0,
        MRW_HALF = 2'd1,
        MRW_BYTE = 2'd2
    } mem_read_width_e;

    // Decoder control word, MSB first. BranchType is two bits wide so the
    // word fills CTRL_W exactly; the width-specific fields hold the encodings above.
    typedef struct packed {
        logic       RegDst;        // [19]
        logic       Branch;        // [18]
        logic [1:0] BranchType;    // [17:16]
        logic       MemtoReg;      // [15]
        logic [3:0] MemWrite;      // [14:11] byte-lane write strobes
        logic       ALUSrc;        // [10]
        logic       ALUShiftImm;   // [9]
        logic       RegWrite;      // [8]
        logic       LoadImm;       // [7]
        logic       ZeroEx;        // [6]
        logic [1:0] memReadWidth;  // [5:4]
        logic [3:0] aluOperation;  // [3:0]
    } ctrl_t;

    // All-zero control word: no register write, no store, no branch.
    localparam ctrl_t BUBBLE = '0;

    // An instruction consumes its rt register when it is not an immediate
    // ALU op, or when it is a store (rt supplies the store data).
    function automatic logic reads_rt(input logic alu_src, input logic [3:0] mem_write);
        return (!alu_src) || (mem_write != 4'd0);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detection against the EX instruction
module load_use_detect
    import datapath_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             i_ex_memtoreg,
    input  logic             i_ex_regwrite,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_id_alusrc,
    input  logic [3:0]       i_id_memwrite,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_hz
);

    logic w_ex_is_load;
    logic w_rs_match;
    logic w_rt_match;

    assign w_ex_is_load = i_ex_memtoreg & i_ex_regwrite & (i_ex_rt != '0);
    assign w_rs_match   = (i_ex_rt == i_id_rs);
    assign w_rt_match   = (i_ex_rt == i_id_rt) & reads_rt(i_id_alusrc, i_id_memwrite);

    // Hazard when the loaded register is consumed by the instruction in ID.
    always_comb begin
        o_hz = w_ex_is_load & (w_rs_match | w_rt_match);
    end

endmodule

// File: rtl/id_ex_stage_register.sv
// rtl/id_ex_stage_register.sv - ID/EX pipeline register with bubble insertion; HAZARD_DETECT_EN enables load-use stall
module id_ex_stage_register
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [15:0]       id_imm,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [REG_W-1:0]  id_shamt,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  ex_shamt,
    output logic              stall
);

    ctrl_t             r_ctrl;
    logic [DATA_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_rdata1;
    logic [DATA_W-1:0] r_rdata2;
    logic [DATA_W-1:0] r_imm_ext;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [REG_W-1:0]  r_shamt;

    ctrl_t             w_id_ctrl;
    logic [DATA_W-1:0] w_imm_ext;
    logic              w_hz;
    logic              w_bubble;

    assign w_id_ctrl = id_ctrl;

    // Extend before the register so EX sees a ready-to-use operand.
    assign w_imm_ext = w_id_ctrl.ZeroEx ? {{(DATA_W-16){1'b0}}, id_imm}
                                        : {{(DATA_W-16){id_imm[15]}}, id_imm};

`ifdef HAZARD_DETECT_EN
    load_use_detect #(
        .REG_W(REG_W)
    ) u_load_use_detect (
        .i_ex_memtoreg (r_ctrl.MemtoReg),
        .i_ex_regwrite (r_ctrl.RegWrite),
        .i_ex_rt       (r_rt),
        .i_id_alusrc   (w_id_ctrl.ALUSrc),
        .i_id_memwrite (w_id_ctrl.MemWrite),
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .o_hz          (w_hz)
    );
`else
    // Software schedules a NOP after every load, so no interlock is needed.
    assign w_hz = 1'b0;
`endif

    // A flush overrides the hazard: a wrong-path instruction must not hold fetch.
    assign w_bubble = flush | w_hz;
    assign stall    = w_hz & ~flush;

    // Pipeline register: reset and bubble both clear, enable=0 freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctrl    <= BUBBLE;
            r_pc4     <= '0;
            r_rdata1  <= '0;
            r_rdata2  <= '0;
            r_imm_ext <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_shamt   <= '0;
        end else if (enable) begin
            if (w_bubble) begin
                r_ctrl    <= BUBBLE;
                r_pc4     <= '0;
                r_rdata1  <= '0;
                r_rdata2  <= '0;
                r_imm_ext <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_rd      <= '0;
                r_shamt   <= '0;
            end else begin
                r_ctrl    <= w_id_ctrl;
                r_pc4     <= id_pc4;
                r_rdata1  <= id_rdata1;
                r_rdata2  <= id_rdata2;
                r_imm_ext <= w_imm_ext;
                r_rs      <= id_rs;
                r_rt      <= id_rt;
                r_rd      <= id_rd;
                r_shamt   <= id_shamt;
            end
        end
    end

    assign ex_ctrl    = r_ctrl;
    assign ex_pc4     = r_pc4;
    assign ex_rdata1  = r_rdata1;
    assign ex_rdata2  = r_rdata2;
    assign ex_imm_ext = r_imm_ext;
    assign ex_rs      = r_rs;
    assign ex_rt      = r_rt;
    assign ex_rd      = r_rd;
    assign ex_shamt   = r_shamt;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// tb/tb_id_ex_stage_register.sv - scoreboard bench for id_ex_stage_register against a behavioural model
module tb_id_ex_stage_register;
    import datapath_pkg::*;

    logic        clk = 1'b0;
    logic        reset, enable, flush;
    logic [19:0] id_ctrl;
    logic [31:0] id_pc4, id_rdata1, id_rdata2;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [19:0] ex_ctrl;
    logic [31:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm_ext;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic        stall;

    id_ex_stage_register #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_shamt(ex_shamt), .stall(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] ctrl;
        logic [31:0] pc4, r1, r2, imm;
        logic [4:0]  rs, rt, rd, sh;
        logic        stall;
    } exp_t;

    exp_t sb_q[$];
    exp_t m;
    exp_t zero_item;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input bit regdst, input bit memtoreg, input bit alusrc,
                                       input bit regwrite, input bit zeroex,
                                       input logic [3:0] memwrite, input logic [3:0] aluop);
        ctrl_t c;
        c = '0;
        c.RegDst       = regdst;
        c.MemtoReg     = memtoreg;
        c.ALUSrc       = alusrc;
        c.RegWrite     = regwrite;
        c.ZeroEx       = zeroex;
        c.MemWrite     = memwrite;
        c.aluOperation = aluop;
        return c;
    endfunction

    // Load-use rule evaluated from the model's EX contents and the ID inputs.
    function automatic logic model_hz();
`ifdef HAZARD_DETECT_EN
        ctrl_t e;
        ctrl_t d;
        bit    uses_rt;
        e = m.ctrl;
        d = id_ctrl;
        uses_rt = (d.ALUSrc == 1'b0) || (d.MemWrite != 4'd0);
        if (!(e.MemtoReg && e.RegWrite)) return 1'b0;
        if (m.rt == 5'd0) return 1'b0;
        return (m.rt == id_rs) || (uses_rt && (m.rt == id_rt));
`else
        return 1'b0;
`endif
    endfunction

    // One cycle: drive ID inputs, push expected outputs, advance the model over the next edge.
    task automatic cyc(input bit en, input bit fl, input bit rst, input logic [19:0] ctrl,
                       input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] data);
        exp_t  e;
        ctrl_t c;
        logic  hz;
        @(posedge clk);
        #1;
        reset = rst; enable = en; flush = fl; id_ctrl = ctrl; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = data[4:0] ^ 5'd9; id_shamt = data[9:5];
        id_pc4 = data + 32'd4; id_rdata1 = data ^ 32'hA5A5_0000; id_rdata2 = ~data;
        if (rst) m = zero_item;
        hz = model_hz();
        e = m;
        e.stall = hz && !fl;
        sb_q.push_back(e);
        c = ctrl;
        if (rst || (en && (fl || hz))) begin
            m = zero_item;
        end else if (en) begin
            m.ctrl = ctrl; m.pc4 = id_pc4; m.r1 = id_rdata1; m.r2 = id_rdata2;
            m.imm  = c.ZeroEx ? {16'h0000, imm} : 32'($signed(imm));
            m.rs = rs; m.rt = rt; m.rd = id_rd; m.sh = id_shamt;
        end
    endtask

    // Monitor: compares the DUT against the oldest expectation on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ex_ctrl",    32'(ex_ctrl),    32'(e.ctrl));
            chk("ex_pc4",     ex_pc4,          e.pc4);
            chk("ex_rdata1",  ex_rdata1,       e.r1);
            chk("ex_rdata2",  ex_rdata2,       e.r2);
            chk("ex_imm_ext", ex_imm_ext,      e.imm);
            chk("ex_rs",      32'(ex_rs),      32'(e.rs));
            chk("ex_rt",      32'(ex_rt),      32'(e.rt));
            chk("ex_rd",      32'(ex_rd),      32'(e.rd));
            chk("ex_shamt",   32'(ex_shamt),   32'(e.sh));
            chk("stall",      32'(stall),      32'(e.stall));
        end
    end

    initial begin
        logic [19:0] addi, andi, lw, add, rc;
        ctrl_t       rcs;
        zero_item = '{ctrl: '0, pc4: '0, r1: '0, r2: '0, imm: '0,
                      rs: '0, rt: '0, rd: '0, sh: '0, stall: 1'b0};
        m = zero_item;
        addi = mk(0, 0, 1, 1, 0, 4'd0, ALU_ADD);
        andi = mk(0, 0, 1, 1, 1, 4'd0, ALU_AND);
        lw   = mk(0, 1, 1, 1, 0, 4'd0, ALU_ADD);
        add  = mk(1, 0, 0, 1, 0, 4'd0, ALU_ADD);
        reset = 1'b1; enable = 1'b1; flush = 1'b0; id_ctrl = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0;
        id_pc4 = '0; id_rdata1 = '0; id_rdata2 = '0;

        // reset state
        cyc(1, 0, 1, addi, 16'h1234, 5'd1, 5'd2, 32'h100);
        cyc(1, 0, 1, addi, 16'h1234, 5'd1, 5'd2, 32'h104);
        // sign and zero extension
        cyc(1, 0, 0, addi, 16'hFFFE, 5'd1, 5'd3, 32'h200);
        cyc(1, 0, 0, andi, 16'hFFFE, 5'd1, 5'd4, 32'h204);
        cyc(1, 0, 0, add,  16'h0000, 5'd2, 5'd3, 32'h208);
        // load-use: LW rt=5 then ADD rs=5, held for the stall cycle
        cyc(1, 0, 0, lw,   16'h0010, 5'd1, 5'd5, 32'h300);
        cyc(1, 0, 0, add,  16'h0000, 5'd5, 5'd6, 32'h304);
        cyc(1, 0, 0, add,  16'h0000, 5'd5, 5'd6, 32'h304);
        cyc(1, 0, 0, add,  16'h0000, 5'd5, 5'd6, 32'h304);
        // store reading rt after a load
        cyc(1, 0, 0, lw,   16'h0020, 5'd1, 5'd8, 32'h310);
        cyc(1, 0, 0, mk(0, 0, 1, 0, 0, 4'hF, ALU_ADD), 16'h0004, 5'd2, 5'd8, 32'h314);
        cyc(1, 0, 0, mk(0, 0, 1, 0, 0, 4'hF, ALU_ADD), 16'h0004, 5'd2, 5'd8, 32'h314);
        // false hazards: rt=0, and ADDI whose rt is a destination
        cyc(1, 0, 0, lw,   16'h0000, 5'd1, 5'd0, 32'h400);
        cyc(1, 0, 0, add,  16'h0000, 5'd0, 5'd0, 32'h404);
        cyc(1, 0, 0, lw,   16'h0000, 5'd1, 5'd7, 32'h408);
        cyc(1, 0, 0, addi, 16'h0001, 5'd1, 5'd7, 32'h40C);
        // flush overrides a hazard
        cyc(1, 0, 0, lw,   16'h0000, 5'd1, 5'd5, 32'h500);
        cyc(1, 1, 0, add,  16'h0000, 5'd5, 5'd6, 32'h504);
        cyc(1, 0, 0, add,  16'h0000, 5'd2, 5'd3, 32'h508);
        // freeze with a pending hazard, changing data inputs
        cyc(1, 0, 0, lw,   16'h0000, 5'd1, 5'd5, 32'h600);
        cyc(0, 0, 0, add,  16'h0000, 5'd5, 5'd6, 32'h604);
        cyc(0, 0, 0, add,  16'h1111, 5'd5, 5'd6, 32'h608);
        cyc(0, 0, 0, addi, 16'h2222, 5'd3, 5'd9, 32'h60C);
        cyc(1, 0, 0, addi, 16'h8000, 5'd3, 5'd9, 32'h610);
        cyc(1, 0, 0, add,  16'h0000, 5'd1, 5'd2, 32'h614);
        // reset asserted mid-cycle over a loaded register
        cyc(1, 0, 1, add,  16'h0000, 5'd1, 5'd2, 32'h700);
        cyc(1, 0, 0, andi, 16'h8001, 5'd1, 5'd2, 32'h704);

        // randomized traffic with small register numbers to provoke hazards
        for (int i = 0; i < 400; i++) begin
            rcs = ctrl_t'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                rcs.MemtoReg = 1'b1;
                rcs.RegWrite = 1'b1;
            end
            rc = rcs;
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                rc, 16'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
